// File: rtl/tape_stream.sv
// Tape image streamer: SRAM download/readback through a prefetch FIFO, toggle req/ack byte delivery.
// Define TAPE_LOOP_EN to replay the image from byte 0 at end of tape instead of stopping.
module tape_stream #(
  parameter int AW    = 21,
  parameter int DEPTH = 4,
  parameter int RLAT  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              eot,
  output logic              restart,
  output logic [AW:0]       pos,
  output logic [DEPTH:0]    level,
  input  logic              req,
  output logic              ack,
  output logic [7:0]        data,
  input  logic              dioEna,
  input  logic [AW-1:0]     dioA,
  input  logic [7:0]        dioD,
  input  logic              dioW,
  input  logic [31:0]       dioSize,
  output logic              sramWe,
  inout  wire  [7:0]        sramDQ,
  output logic [AW-1:0]     sramA
);

  localparam int ENTRIES = 1 << DEPTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t             state, state_nx;
  logic [2:0]         wcnt;
  logic [AW:0]        size, fetch_addr, addr_inc;
  logic [DEPTH-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH:0]     count, count_nx;
  logic [7:0]         fifo_mem [ENTRIES];
  logic               req_r, pending, empty, full;
  logic               start_go, abort, push, pop, end_cond;

  // Sizes with any bit above bit AW clamp to the full address space.
  function automatic logic [AW:0] sat_size(input logic [31:0] s);
    if ((s >> (AW + 1)) != 32'd0) return {1'b1, {AW{1'b0}}};
    return s[AW:0];
  endfunction

  assign sramWe = ~dioW;
  assign sramDQ = sramWe ? 8'bz : dioD;
  assign sramA  = dioEna ? dioA : fetch_addr[AW-1:0];

  assign start_go = start & ~stop;
  assign abort    = dioEna | start | stop;
  assign empty    = (count == '0);
  assign full     = count[DEPTH];
  assign pending  = (req_r != ack);
  assign push     = (state == WRITE) && !abort;
  assign pop      = pending && !empty && !start_go;
  assign count_nx = count + (DEPTH+1)'(push) - (DEPTH+1)'(pop);
  assign addr_inc = fetch_addr + (AW+1)'(1);
  assign end_cond = busy && (fetch_addr == size) && empty && !pending;
  assign level    = count;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (busy && !abort && (fetch_addr < size) && !full) state_nx = ISSUE;
      ISSUE: state_nx = abort ? IDLE : WAIT;
      WAIT: begin
        if (abort)             state_nx = IDLE;
        else if (wcnt == '0)   state_nx = WRITE;
      end
      // Chain straight into the next fetch so throughput stays one byte per RLAT+2 cycles.
      WRITE: begin
        if (!abort && busy && (addr_inc < size) && !count_nx[DEPTH]) state_nx = ISSUE;
        else                                                         state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == ISSUE)   wcnt <= 3'(RLAT - 1);
      else if (wcnt != '0)  wcnt <= wcnt - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= 1'b0;
      eot        <= 1'b0;
      restart    <= 1'b0;
      ack        <= 1'b0;
      data       <= '0;
      pos        <= '0;
      fetch_addr <= '0;
      size       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      req_r      <= 1'b0;
    end else begin
      restart <= 1'b0;
      req_r   <= req;
      if (dioEna) size <= sat_size(dioSize);
      if (start_go) begin
        busy       <= 1'b1;
        eot        <= 1'b0;
        restart    <= 1'b1;
        pos        <= '0;
        fetch_addr <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        ack        <= req;
      end else begin
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          fetch_addr <= addr_inc;
        end
        if (pop) begin
          data   <= fifo_mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
          pos    <= pos + (AW+1)'(1);
          ack    <= req_r;
        end
        count <= count_nx;
        if (stop) begin
          busy <= 1'b0;
        end else if (end_cond) begin
`ifdef TAPE_LOOP_EN
          fetch_addr <= '0;
          pos        <= '0;
          restart    <= 1'b1;
`else
          eot  <= 1'b1;
          busy <= 1'b0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= sramDQ;
  end

endmodule

// File: tb/tb_tape_stream.sv
// Self-checking bench for tape_stream: SRAM model, random images, byte-stream reference from the download.
module tb_tape_stream;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int RLAT  = 1;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              stop    = 1'b0;
  logic              req     = 1'b0;
  logic              dioEna  = 1'b0;
  logic              dioW    = 1'b0;
  logic [7:0]        dioD    = '0;
  logic [AW-1:0]     dioA    = '0;
  logic [31:0]       dioSize = '0;
  logic              busy, eot, restart, ack, sramWe;
  logic [AW:0]       pos;
  logic [DEPTH:0]    level;
  logic [7:0]        data;
  logic [AW-1:0]     sramA;
  wire  [7:0]        sramDQ;

  int checks = 0;
  int errors = 0;
  int restart_cnt = 0;
  logic eot_seen = 1'b0;

  logic [7:0] exp_img [256];
  logic [7:0] mem [256];
  logic [7:0] rd_pipe [RLAT];

  always #5 clock = ~clock;

  tape_stream #(.AW(AW), .DEPTH(DEPTH), .RLAT(RLAT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .busy(busy), .eot(eot), .restart(restart), .pos(pos), .level(level),
    .req(req), .ack(ack), .data(data),
    .dioEna(dioEna), .dioA(dioA), .dioD(dioD), .dioW(dioW), .dioSize(dioSize),
    .sramWe(sramWe), .sramDQ(sramDQ), .sramA(sramA)
  );

  // External SRAM: writes on low sramWe, read data appears RLAT clocks after the address.
  always @(posedge clock) begin
    rd_pipe[0] <= mem[sramA];
    for (int i = 1; i < RLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (!sramWe) mem[sramA] <= sramDQ;
    if (restart) restart_cnt <= restart_cnt + 1;
    if (eot) eot_seen <= 1'b1;
  end
  assign sramDQ = sramWe ? rd_pipe[RLAT-1] : 8'bz;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic download(input int n, input logic [31:0] sz, input bit fixed);
    dioEna  = 1'b1;
    dioSize = sz;
    for (int i = 0; i < n; i++) begin
      dioA = AW'(i);
      dioD = fixed ? 8'(17 * (i + 1)) : 8'($urandom);
      exp_img[i] = dioD;
      dioW = 1'b1;
      cyc(1);
    end
    dioW = 1'b0;
    cyc(1);
    dioEna = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int first, input int n,
                       input bit blips, input logic [31:0] sz);
    bit ok;
    for (int i = first; i < n; i++) begin
      if (blips && $urandom_range(0, 3) == 0) begin
        dioEna  = 1'b1;
        dioSize = sz;
        cyc($urandom_range(1, 3));
        dioEna  = 1'b0;
      end else begin
        cyc($urandom_range(0, 2));
      end
      req = ~req;
      ok  = 1'b0;
      for (int k = 0; k < 100; k++) begin
        cyc(1);
        if (ack === req) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s ack_timeout byte %0d ack=%b req=%b", name, i, ack, req);
      end else if (data !== exp_img[i]) begin
        errors++;
        $display("FAIL %s data byte %0d got %02h want %02h", name, i, data, exp_img[i]);
      end
      checks++;
      if (pos !== (AW+1)'(i + 1)) begin
        errors++;
        $display("FAIL %s pos byte %0d got %0d want %0d", name, i, pos, i + 1);
      end
    end
  endtask

  task automatic wait_eot(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (eot === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s eot got eot=%b busy=%b want eot=1 busy=0", name, eot, busy);
    end
  endtask

  task automatic test_reset;
    cyc(2);
    checks++;
    if ({busy, eot, restart, ack} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {busy, eot, restart, ack});
    end
    checks++;
    if (data !== 8'h00 || pos !== '0 || level !== '0) begin
      errors++;
      $display("FAIL reset_counts got data=%h pos=%0d level=%0d want 0", data, pos, level);
    end
    checks++;
    if (sramWe !== 1'b1 || sramA !== '0) begin
      errors++;
      $display("FAIL reset_sram got we=%b a=%h want we=1 a=00", sramWe, sramA);
    end
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic;
    download(5, 32'd5, 1'b1);
    pulse_start;
    checks++;
    if (restart !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start got restart=%b busy=%b want 1 1", restart, busy);
    end
    cyc(1);
    checks++;
    if (restart !== 1'b0) begin
      errors++;
      $display("FAIL basic_restart_width got %b want 0", restart);
    end
    cyc(2);
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL basic_level_before_push got %0d want 0", level);
    end
    cyc(1);
    checks++;
    if (level !== (DEPTH+1)'(1)) begin
      errors++;
      $display("FAIL basic_first_push got %0d want 1", level);
    end
    req = ~req;
    cyc(1);
    checks++;
    if (ack === req) begin
      errors++;
      $display("FAIL basic_ack_early got ack=%b want %b", ack, ~req);
    end
    cyc(1);
    checks++;
    if (ack !== req || data !== 8'h11 || pos !== (AW+1)'(1)) begin
      errors++;
      $display("FAIL basic_first_byte got ack=%b data=%h pos=%0d want %b 11 1", ack, data, pos, req);
    end
    drain("basic", 1, 5, 1'b0, 32'd5);
    wait_eot("basic");
    checks++;
    if (pos !== (AW+1)'(5)) begin
      errors++;
      $display("FAIL basic_final_pos got %0d want 5", pos);
    end
  endtask

  task automatic test_fill;
    int sz = $urandom_range(20, 120);
    download(sz, 32'(sz), 1'b0);
    pulse_start;
    cyc(80);
    checks++;
    if (level !== (DEPTH+1)'(16) || sramA !== AW'(16)) begin
      errors++;
      $display("FAIL fill_park got level=%0d sramA=%0d want 16 16", level, sramA);
    end
    checks++;
    if (busy !== 1'b1 || eot !== 1'b0) begin
      errors++;
      $display("FAIL fill_state got busy=%b eot=%b want 1 0", busy, eot);
    end
    drain("fill", 0, sz, 1'b0, 32'(sz));
    wait_eot("fill");
  endtask

  task automatic test_dio_abort;
    int sz = 20;
    download(sz, 32'(sz), 1'b0);
    pulse_start;
    cyc(2);
    dioEna  = 1'b1;
    dioA    = 8'hA5;
    dioSize = 32'(sz);
    #1;
    checks++;
    if (sramA !== 8'hA5) begin
      errors++;
      $display("FAIL abort_sram_mux got %h want a5", sramA);
    end
    cyc(3);
    dioEna = 1'b0;
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL abort_no_push got %0d want 0", level);
    end
    drain("abort", 0, sz, 1'b1, 32'(sz));
    wait_eot("abort");
  endtask

  task automatic test_start_stop;
    download(30, 32'd30, 1'b0);
    pulse_start;
    drain("stop_pre", 0, 3, 1'b0, 32'd30);
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || restart !== 1'b0 || pos !== (AW+1)'(3)) begin
      errors++;
      $display("FAIL stop_wins got busy=%b restart=%b pos=%0d want 0 0 3", busy, restart, pos);
    end
    cyc(1);
    checks++;
    if (restart !== 1'b0 || pos !== (AW+1)'(3)) begin
      errors++;
      $display("FAIL stop_hold got restart=%b pos=%0d want 0 3", restart, pos);
    end
    pulse_start;
    checks++;
    if (pos !== '0 || level !== '0 || restart !== 1'b1) begin
      errors++;
      $display("FAIL restart_flush got pos=%0d level=%0d restart=%b want 0 0 1", pos, level, restart);
    end
    drain("restart", 0, 30, 1'b0, 32'd30);
    wait_eot("restart");
  endtask

  task automatic test_size0;
    download(0, 32'd0, 1'b0);
    pulse_start;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL size0_busy got %b want 1", busy);
    end
    cyc(1);
    checks++;
    if (eot !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL size0_eot got eot=%b busy=%b want 1 0", eot, busy);
    end
  endtask

  task automatic test_saturate;
    download(256, 32'h0000_0200, 1'b0);
    pulse_start;
    drain("saturate", 0, 256, 1'b0, 32'h0000_0200);
    wait_eot("saturate");
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b0;
    download(30, 32'd30, 1'b0);
    pulse_start;
    for (int k = 0; k < 100; k++) begin
      if (level === (DEPTH+1)'(7)) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_level got %0d want 7", level);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, eot, restart, ack} !== 4'b0000 || data !== 8'h00 || pos !== '0 || level !== '0 ||
        sramA !== '0 || sramWe !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async got busy=%b eot=%b restart=%b ack=%b data=%h pos=%0d level=%0d a=%h",
               busy, eot, restart, ack, data, pos, level, sramA);
    end
    #2 reset_n = 1'b1;
    cyc(1);
  endtask

`ifdef TAPE_LOOP_EN
  task automatic test_loop;
    int base;
    bit ok;
    download(3, 32'd3, 1'b0);
    pulse_start;
    cyc(2);
    base = restart_cnt;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      req = ~req;
      ok  = 1'b0;
      for (int k = 0; k < 100; k++) begin
        cyc(1);
        if (ack === req) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok || data !== exp_img[i % 3]) begin
        errors++;
        $display("FAIL loop_byte %0d got ok=%b data=%h want %h", i, ok, data, exp_img[i % 3]);
      end
    end
    cyc(2);
    checks++;
    if (restart_cnt - base !== 2 || eot_seen !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL loop_state got restarts=%0d eot_seen=%b busy=%b want 2 0 1",
               restart_cnt - base, eot_seen, busy);
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef TAPE_LOOP_EN
    test_loop;
`else
    test_basic;
    test_fill;
    test_dio_abort;
    test_start_stop;
    test_size0;
    test_saturate;
    test_reset_mid;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tape_stream.md
# tape_stream

Parametrised tape-image streamer between the shared external SRAM and the tape player core. It stores a downloaded image in SRAM through the download port and later reads it back through a prefetch FIFO. It serves bytes to the player over a toggle request/acknowledge handshake, and it owns the motor, restart and end-of-tape indications. This generation adds configurable address width, FIFO depth and SRAM read latency. It also adds byte-position and fill-level reporting, FIFO back-pressure, and optional looping.

## Interface
Parameters:
- AW, 21, SRAM address width in bytes
- DEPTH, 4, log2 of prefetch FIFO entries (16 entries at default)
- RLAT, 1, SRAM read-data latency in clocks after the address is driven (1..7)

Ports:
- clock  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; rewind to byte 0 and run
- stop  in  1  one-cycle pulse; halt playback
- busy  out  1  motor on (playback running)
- eot  out  1  end of tape reached
- restart  out  1  one-cycle pulse to the player on every accepted start
- pos  out  AW+1  count of bytes delivered to the player since start
- level  out  DEPTH+1  FIFO occupancy
- req  in  1  player request toggle
- ack  out  1  acknowledge toggle
- data  out  8  byte for the player; valid when ack equals req
- dioEna  in  1  download active
- dioA  in  AW  download address
- dioD  in  8  download data
- dioW  in  1  download write strobe
- dioSize  in  32  image size in bytes
- sramWe  out  1  SRAM write enable, active low
- sramDQ  inout  8  SRAM data
- sramA  out  AW  SRAM address

## Operation
- Image size register:
  - Latched from dioSize every cycle while dioEna is high.
  - Width is AW+1. If any bit of dioSize above bit AW is set, the value saturates to 2^AW.
- SRAM port:
  - sramWe = ~dioW.
  - sramDQ is driven with dioD only while sramWe is low; otherwise it is high-Z.
  - sramA = dioA while dioEna is high; otherwise it is the fetch address.
- Fetch FSM, states IDLE → ISSUE → WAIT → WRITE → ISSUE/IDLE:
  - IDLE: leave IDLE when busy is high, dioEna is low, the fetch address is below size, and the FIFO is not full.
  - ISSUE: drive the fetch address.
  - WAIT: hold the address for RLAT cycles.
  - WRITE: capture sramDQ into the FIFO and increment the fetch address.
  - If dioEna rises, or start/stop is seen, in any non-IDLE state: abort to IDLE and discard the in-flight byte. The fetch address is not incremented.
- Consumer:
  - A request is a registered change of req (req ≠ req_d, held pending).
  - When a request is pending and the FIFO is not empty, pop the FIFO into data, increment pos, and set ack to req.
  - A pending request waits indefinitely while the FIFO is empty and the image is not exhausted.
- start:
  - Flush the FIFO, zero the fetch address and pos, clear eot, set busy, pulse restart, and set ack to the current req.
- stop:
  - Clear busy and abort any fetch. FIFO contents and pos are retained; the next start flushes them.
- Simultaneous start and stop: stop wins and start is ignored.
- End of tape: when the fetch address equals size, the FIFO is empty and no request is pending, eot rises and busy clears. eot holds until the next start.
- Size 0: start sets busy; the following cycle satisfies the end-of-tape condition.

## Timing
- Reset values: busy 0, eot 0, restart 0, ack 0, data 0, pos 0, level 0, FSM in IDLE, fetch address 0. sramWe and sramA follow their combinational definitions.
- Fetch throughput: one byte per RLAT+2 cycles (ISSUE, RLAT cycles of WAIT, WRITE).
- FIFO write-to-read: a byte written in cycle n is poppable in cycle n+1. level updates in the same cycle as the push or pop. A simultaneous push and pop leaves level unchanged.
- Request to ack: if req toggles in cycle n and the FIFO is non-empty, data and ack update in cycle n+2.
- First byte after start at default RLAT: the first push happens 4 cycles after start. With a request already pending, ack follows at cycle 5.
- restart: high exactly one cycle, the cycle after start is sampled.
- Wrap-around: pos and the fetch address never wrap. A size of 2^AW is reached exactly via the AW+1-bit counters.

## Configuration
- TAPE_LOOP_EN defined: at the end-of-tape condition, the fetch address and pos reset to 0, restart pulses, busy stays high and eot stays low. Playback repeats until stop.
- TAPE_LOOP_EN undefined: end-of-tape behaviour as above (eot set, busy cleared).

## Test plan
- Download 5 bytes 0x11..0x55 (dioSize=5), start, toggle req 5 times → data 0x11..0x55 in order, pos=5, then eot=1 and busy=0.
- Start with no requests, RLAT=1, DEPTH=4, size=100 → level saturates at 16, fetch FSM parks in IDLE, sramA holds 16.
- dioEna raised while the FSM is in WAIT → that byte is refetched after dioEna falls; the delivered stream has no gap or duplicate.
- start and stop in the same cycle while running → busy=0, no restart pulse, pos unchanged.
- Assert reset_n low mid-playback with level=7 → all outputs take their reset values immediately, without waiting for a clock edge.
- With TAPE_LOOP_EN, size=3 and bytes A,B,C, 7 requests → A,B,C,A,B,C,A delivered, two restart pulses, eot never set.
